// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned COMMON_WIDTH = 32;
  localparam logic [COMMON_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    STALLED,
    DRAIN
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [COMMON_WIDTH-1:0] align_word(input logic [COMMON_WIDTH-1:0] addr);
    return {addr[COMMON_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter: reset / aligned redirect / sequential advance / hold.
module pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [COMMON_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_ce,
  input  logic [COMMON_WIDTH-1:0] redirect_addr,
  input  logic                    advance,
  output logic [COMMON_WIDTH-1:0] pc,
  output logic [COMMON_WIDTH-1:0] next_pc_c
);

  // Redirect wins over a sequential advance; the add wraps modulo 2^32.
  always_comb begin
    next_pc_c = pc;
    if (redirect_ce) begin
      next_pc_c = align_word(redirect_addr);
    end else if (advance) begin
      next_pc_c = pc + COMMON_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc_c;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: one outstanding instruction-memory read, valid/ready hand-off to decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [COMMON_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [COMMON_WIDTH-1:0] NOP_INST = inst_fetch_pkg::NOP_INST
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_req,
  output logic [COMMON_WIDTH-1:0] mem_addr,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [COMMON_WIDTH-1:0] mem_rdata,
  output logic [COMMON_WIDTH-1:0] inst,
  output logic [COMMON_WIDTH-1:0] pc_addr,
  output logic                    inst_valid,
  input  logic                    dec_ready,
  input  logic                    stall,
  input  logic                    redirect_ce,
  input  logic [COMMON_WIDTH-1:0] redirect_addr
);

  fetch_state_e            state;
  logic [COMMON_WIDTH-1:0] pc;
  logic [COMMON_WIDTH-1:0] next_pc_c;
  logic                    advance_c;

  assign advance_c = (state == OUT) && inst_valid && dec_ready && !stall;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .redirect_ce  (redirect_ce),
    .redirect_addr(redirect_addr),
    .advance      (advance_c),
    .pc           (pc),
    .next_pc_c    (next_pc_c)
  );

  // Entering REQ always loads mem_addr from next_pc_c, so it tracks redirects and pc+4.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      inst       <= NOP_INST;
      pc_addr    <= '0;
      inst_valid <= 1'b0;
    end else if (redirect_ce) begin
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      case (state)
        REQ: begin
          if (mem_ready) begin
            state   <= DRAIN;
            mem_req <= 1'b0;
          end else begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= next_pc_c;
          end
        end
        WAIT, DRAIN: begin
          // A response landing in the redirect cycle retires the outstanding read.
          if (mem_rvalid) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= next_pc_c;
          end else begin
            state   <= DRAIN;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= next_pc_c;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= next_pc_c;
        end
        REQ: begin
          if (mem_ready) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state      <= OUT;
            inst       <= mem_rdata;
            pc_addr    <= pc;
            inst_valid <= 1'b1;
          end
        end
        OUT: begin
          if (inst_valid && dec_ready) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            if (stall) begin
              state <= STALLED;
            end else begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= next_pc_c;
            end
          end
        end
        STALLED: begin
          state <= STALLED;
        end
        DRAIN: begin
          if (mem_rvalid) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= next_pc_c;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small latency-programmable instruction memory.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [31:0] pc_addr;
  logic        inst_valid;
  logic        dec_ready = 1'b1;
  logic        stall;
  logic        redirect_ce = 1'b0;
  logic [31:0] redirect_addr = '0;

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  int          cnt = 0;
  bit          jal_on = 1'b1;
  logic [31:0] paddr = '0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .inst         (inst),
    .pc_addr      (pc_addr),
    .inst_valid   (inst_valid),
    .dec_ready    (dec_ready),
    .stall        (stall),
    .redirect_ce  (redirect_ce),
    .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_on && a == 32'h8) return JAL;
    return a ^ 32'h5A00_0000;
  endfunction

  // Memory: accepts while mem_ready, answers lat cycles after the request cycle.
  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (cnt == 1) begin
      m_rvalid <= 1'b1;
      m_rdata  <= mem_word(paddr);
      cnt      <= 0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
    if (mem_req && mem_ready) begin
      if (lat <= 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_word(mem_addr);
      end else begin
        paddr <= mem_addr;
        cnt   <= lat - 1;
      end
    end
  end

  assign mem_rvalid = m_rvalid;
  assign mem_rdata  = m_rdata;
  assign stall      = inst_valid && (inst[6:0] == 7'h6F);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_pc_addr"}, pc_addr, 32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    chk("idle_no_req", 32'(mem_req), 32'd0);
    tick();

    // Streaming fetch 0,4,8; the word at 8 is a JAL that stalls the decoder.
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("req%0d", k), 32'(mem_req), 32'd1);
      chk($sformatf("req_addr%0d", k), mem_addr, 32'(4 * k));
      tick();
      chk($sformatf("wait_no_req%0d", k), 32'(mem_req), 32'd0);
      tick();
      chk($sformatf("valid%0d", k), 32'(inst_valid), 32'd1);
      chk($sformatf("pc_addr%0d", k), pc_addr, 32'(4 * k));
      chk($sformatf("inst%0d", k), inst, mem_word(32'(4 * k)));
      if (k < 2) tick();
    end
    chk("jal_stall", 32'(stall), 32'd1);
    tick();
    chk("stalled_valid", 32'(inst_valid), 32'd0);
    chk("stalled_nop", inst, NOP);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stalled_no_req%0d", i), 32'(mem_req), 32'd0);
      tick();
    end
    jal_on = 1'b0;
    redirect_ce = 1'b1;
    redirect_addr = 32'h100;
    tick();
    redirect_ce = 1'b0;
    chk("redir_req", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, 32'h100);

    // Decoder back-pressure for five cycles.
    dec_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_valid%0d", i), 32'(inst_valid), 32'd1);
      chk($sformatf("hold_pc%0d", i), pc_addr, 32'h100);
      chk($sformatf("hold_inst%0d", i), inst, mem_word(32'h100));
      chk($sformatf("hold_no_req%0d", i), 32'(mem_req), 32'd0);
      if (i < 4) tick();
    end
    dec_ready = 1'b1;
    tick();
    chk("accept_req", 32'(mem_req), 32'd1);
    chk("accept_addr", mem_addr, 32'h104);

    // Redirect while waiting; the late response must be dropped.
    lat = 3;
    tick();
    redirect_ce = 1'b1;
    redirect_addr = 32'h40;
    tick();
    redirect_ce = 1'b0;
    chk("drain1_no_req", 32'(mem_req), 32'd0);
    chk("drain1_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("drain2_no_req", 32'(mem_req), 32'd0);
    chk("drain2_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("post_drain_req", 32'(mem_req), 32'd1);
    chk("post_drain_addr", mem_addr, 32'h40);
    chk("post_drain_valid", 32'(inst_valid), 32'd0);
    lat = 1;
    tick();
    tick();
    chk("redir40_valid", 32'(inst_valid), 32'd1);
    chk("redir40_pc", pc_addr, 32'h40);
    chk("redir40_inst", inst, mem_word(32'h40));
    tick();
    chk("seq44_addr", mem_addr, 32'h44);

    // Unaligned redirect target and PC wrap at the top of memory.
    mem_ready = 1'b0;
    redirect_ce = 1'b1;
    redirect_addr = 32'h43;
    tick();
    chk("align_req", 32'(mem_req), 32'd1);
    chk("align_addr", mem_addr, 32'h40);
    redirect_addr = 32'hFFFF_FFFC;
    tick();
    redirect_ce = 1'b0;
    chk("top_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("top_hold_req", 32'(mem_req), 32'd1);
    chk("top_hold_addr", mem_addr, 32'hFFFF_FFFC);
    mem_ready = 1'b1;
    tick();
    tick();
    chk("top_valid", 32'(inst_valid), 32'd1);
    chk("top_pc", pc_addr, 32'hFFFF_FFFC);
    chk("top_inst", inst, mem_word(32'hFFFF_FFFC));
    tick();
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_req", 32'(mem_req), 32'd1);

    // Reset mid-read; the stale response lands during IDLE.
    lat = 3;
    tick();
    rst = 1'b1;
    tick();
    chk_reset("midreset");
    tick();
    rst = 1'b0;
    chk("stale_idle_req", 32'(mem_req), 32'd0);
    chk("stale_idle_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("restart_req", 32'(mem_req), 32'd1);
    chk("restart_addr", mem_addr, 32'h0);
    chk("restart_valid", 32'(inst_valid), 32'd0);
    lat = 1;
    tick();
    tick();
    chk("restart_out_valid", 32'(inst_valid), 32'd1);
    chk("restart_out_pc", pc_addr, 32'h0);
    chk("restart_out_inst", inst, mem_word(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
